// File: rtl/rotr_arb_64b.sv
// rtl/rotr_arb_64b.sv - round-robin arbiter sharing one 64-bit rotator between two requesters
// Optional grant counters are compiled only when ROTR_ARB_STAT_EN is defined.
module rotr_arb_64b #(
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0][63:0]      in_data_i,
  input  logic [1:0][5:0]       in_shift_i,
  input  logic [1:0]            in_valid_i,
  output logic [1:0]            in_ready_o,
  output logic [1:0][63:0]      out_data_o,
  output logic [1:0]            out_valid_o,
  input  logic [1:0]            out_ready_i,
  output logic [63:0]           rot_data_o,
  output logic [5:0]            rot_shift_o,
  output logic                  rot_valid_o,
  input  logic [63:0]           rot_data_i,
  input  logic                  rot_valid_i,
  output logic                  err_o,
  output logic [1:0][CNT_W-1:0] stat_cnt_o
);

  logic [1:0]       pend_q, pend_d;
  logic             last_q, last_d;
  logic [1:0]       tag_q, tag_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0][63:0] out_data_q, out_data_d;
  logic [1:0]       out_valid_q, out_valid_d;
  logic [63:0]      rot_data_q, rot_data_d;
  logic [5:0]       rot_shift_q, rot_shift_d;
  logic             rot_valid_q, rot_valid_d;
  logic             err_q, err_d;

  logic [1:0] elig;
  logic [1:0] grant;
  logic       gnt_idx;
  logic       push;
  logic       pop;
  logic       pop_tag;
  logic [1:0] xfer;

  // last_q holds the index granted most recently; both eligible -> the other one wins
  always_comb begin
    elig  = in_valid_i & ~pend_q;
    grant = 2'b00;
    if (!rst_i) begin
      case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    gnt_idx = grant[1];
    push    = |grant;
    pop     = rot_valid_i && (cnt_q != 2'd0);
    pop_tag = tag_q[rd_ptr_q];
    xfer    = out_valid_q & out_ready_i;
  end

  always_comb begin
    pend_d      = (pend_q & ~xfer) | grant;
    last_d      = push ? gnt_idx : last_q;
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~xfer;
    rot_data_d  = rot_data_q;
    rot_shift_d = rot_shift_q;
    rot_valid_d = push;
    err_d       = err_q | (rot_valid_i && (cnt_q == 2'd0));
    if (push) begin
      tag_d[wr_ptr_q] = gnt_idx;
      rot_data_d      = in_data_i[gnt_idx];
      rot_shift_d     = in_shift_i[gnt_idx];
    end
    if (pop) begin
      out_data_d[pop_tag]  = rot_data_i;
      out_valid_d[pop_tag] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q      <= 2'b00;
      last_q      <= 1'b1;
      tag_q       <= 2'b00;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 2'b00;
      rot_data_q  <= '0;
      rot_shift_q <= '0;
      rot_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rot_data_q  <= rot_data_d;
      rot_shift_q <= rot_shift_d;
      rot_valid_q <= rot_valid_d;
      err_q       <= err_d;
    end
  end

  assign in_ready_o  = grant;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign rot_data_o  = rot_data_q;
  assign rot_shift_o = rot_shift_q;
  assign rot_valid_o = rot_valid_q;
  assign err_o       = err_q;

`ifdef ROTR_ARB_STAT_EN
  logic [1:0][CNT_W-1:0] stat_q;

  // saturating per-requester grant counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (grant[k] && (stat_q[k] != {CNT_W{1'b1}})) begin
          stat_q[k] <= stat_q[k] + CNT_W'(1);
        end
      end
    end
  end

  assign stat_cnt_o = stat_q;
`else
  assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rotr_arb_64b.sv
// tb/tb_rotr_arb_64b.sv - directed self-checking bench for rotr_arb_64b with a latency-1 rotator model
module tb_rotr_arb_64b;

  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0][63:0]      in_data;
  logic [1:0][5:0]       in_shift;
  logic [1:0]            in_valid;
  logic [1:0]            in_ready;
  logic [1:0][63:0]      out_data;
  logic [1:0]            out_valid;
  logic [1:0]            out_ready;
  logic [63:0]           rot_data_o;
  logic [5:0]            rot_shift_o;
  logic                  rot_valid_o;
  logic [63:0]           rot_data_i;
  logic                  rot_valid_i;
  logic                  err;
  logic [1:0][CNT_W-1:0] stat_cnt;

  logic        mdl_v = 1'b0;
  logic [63:0] mdl_d = '0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rotr_arb_64b #(.CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_shift_i  (in_shift),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .rot_data_o  (rot_data_o),
    .rot_shift_o (rot_shift_o),
    .rot_valid_o (rot_valid_o),
    .rot_data_i  (rot_data_i),
    .rot_valid_i (rot_valid_i),
    .err_o       (err),
    .stat_cnt_o  (stat_cnt)
  );

  function automatic logic [63:0] rotr(input logic [63:0] d, input logic [5:0] s);
    logic [127:0] t;
    t = {d, d} >> s;
    return t[63:0];
  endfunction

  // external rotator with one cycle of latency
  always @(posedge clk) begin
    mdl_v <= rot_valid_o;
    mdl_d <= rotr(rot_data_o, rot_shift_o);
  end
  assign rot_valid_i = mdl_v;
  assign rot_data_i  = mdl_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_op(input int k, input logic [63:0] d, input logic [5:0] s,
                        output logic [63:0] res, output logic ok);
    logic got;
    got = 1'b0;
    ok  = 1'b0;
    res = '0;
    in_data[k]   = d;
    in_shift[k]  = s;
    out_ready[k] = 1'b1;
    in_valid[k]  = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready[k] === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    step();
    in_valid[k] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid[k] === 1'b1) begin
        res = out_data[k];
        ok  = got;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 2'b11;
    out_ready = 2'b00;
    in_data   = '0;
    in_shift  = '0;
    drain(3);
    n_total++; if (in_ready !== 2'b00) $display("FAIL reset_in_ready: got %b want 00", in_ready); else n_pass++;
    n_total++; if (out_valid !== 2'b00) $display("FAIL reset_out_valid: got %b want 00", out_valid); else n_pass++;
    n_total++; if (rot_valid_o !== 1'b0) $display("FAIL reset_rot_valid: got %b want 0", rot_valid_o); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_total++; if (stat_cnt !== '0) $display("FAIL reset_stat: got %h want 0", stat_cnt); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
    n_total++; if (rot_data_o !== 64'h0 || rot_shift_o !== 6'd0)
      $display("FAIL reset_rot_bus: got %h/%0d want 0/0", rot_data_o, rot_shift_o); else n_pass++;
    rst      = 1'b0;
    in_valid = 2'b00;
    step();
  endtask

  task automatic test_single();
    logic ok;
    in_data[0]  = 64'h0123456789abcdef;
    in_shift[0] = 6'd4;
    in_valid    = 2'b01;
    out_ready   = 2'b00;
    #1;
    n_total++; if (in_ready !== 2'b01) $display("FAIL single_grant: got %b want 01", in_ready); else n_pass++;
    step();
    in_valid = 2'b00;
    n_total++; if (rot_valid_o !== 1'b1 || rot_data_o !== 64'h0123456789abcdef || rot_shift_o !== 6'd4)
      $display("FAIL single_issue: got v=%b d=%h s=%0d want v=1 d=0123456789abcdef s=4", rot_valid_o, rot_data_o, rot_shift_o);
    else n_pass++;
    step();
    n_total++; if (rot_valid_o !== 1'b0) $display("FAIL single_issue_drop: got %b want 0", rot_valid_o); else n_pass++;
    step();
    n_total++; if (out_valid !== 2'b01 || out_data[0] !== 64'hf0123456789abcde)
      $display("FAIL single_result: got v=%b d=%h want v=01 d=f0123456789abcde", out_valid, out_data[0]);
    else n_pass++;
    in_valid = 2'b01;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid[0] !== 1'b1 || out_data[0] !== 64'hf0123456789abcde || in_ready[0] !== 1'b0) ok = 1'b0;
    end
    n_total++; if (!ok) $display("FAIL single_hold: got v=%b d=%h rdy=%b want v=1 d=f0123456789abcde rdy=0", out_valid[0], out_data[0], in_ready[0]);
    else n_pass++;
    out_ready = 2'b01;
    #1;
    n_total++; if (in_ready !== 2'b00) $display("FAIL single_no_grant_on_xfer: got %b want 00", in_ready); else n_pass++;
    step();
    n_total++; if (out_valid !== 2'b00) $display("FAIL single_cleared: got %b want 00", out_valid); else n_pass++;
    n_total++; if (in_ready !== 2'b01) $display("FAIL single_regrant: got %b want 01", in_ready); else n_pass++;
    step();
    in_valid = 2'b00;
    drain(4);
  endtask

  task automatic test_alternate();
    int   g[$];
    int   collide;
    int   seen1;
    int   bad1;
    logic last;
    rst = 1'b1;
    step();
    rst = 1'b0;
    collide = 0;
    seen1   = 0;
    bad1    = 0;
    in_data[0]  = 64'h0123456789abcdef;
    in_shift[0] = 6'd4;
    in_data[1]  = 64'hfedcba9876543210;
    in_shift[1] = 6'd8;
    in_valid    = 2'b11;
    out_ready   = 2'b11;
    #1;
    for (int i = 0; i < 14; i++) begin
      if (in_ready === 2'b11) collide++;
      if (in_ready !== 2'b00) g.push_back(int'(in_ready[1]));
      if (out_valid[1] === 1'b1) begin
        seen1++;
        if (out_data[1] !== 64'h10fedcba98765432) bad1++;
      end
      step();
    end
    n_total++; if (g.size() < 4) $display("FAIL alt_grant_count: got %0d want >=4", g.size());
    else if (g[0] != 0 || g[1] != 1 || g[2] != 0 || g[3] != 1)
      $display("FAIL alt_order: got %0d%0d%0d%0d want 0101", g[0], g[1], g[2], g[3]);
    else n_pass++;
    n_total++; if (collide != 0) $display("FAIL alt_one_grant: got %0d double grants want 0", collide); else n_pass++;
    n_total++; if (seen1 == 0 || bad1 != 0) $display("FAIL alt_req1_data: got seen=%0d bad=%0d want seen>0 bad=0", seen1, bad1);
    else n_pass++;
    last = (g.size() > 0) ? g[g.size()-1][0] : 1'b0;
    in_valid = 2'b00;
    drain(6);
    in_valid = 2'b11;
    #1;
    n_total++; if (in_ready !== (last ? 2'b01 : 2'b10))
      $display("FAIL alt_rr_pointer: got %b want %b", in_ready, (last ? 2'b01 : 2'b10));
    else n_pass++;
    step();
    in_valid = 2'b00;
    drain(6);
  endtask

  task automatic test_stall();
    int bad0;
    int gr1;
    int bad1;
    bad0 = 0;
    gr1  = 0;
    bad1 = 0;
    in_data[0]  = 64'h1122334455667788;
    in_shift[0] = 6'd16;
    in_data[1]  = 64'hfedcba9876543210;
    in_shift[1] = 6'd8;
    out_ready   = 2'b10;
    in_valid    = 2'b01;
    #1;
    step();
    in_valid = 2'b11;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready[0] !== 1'b0) bad0++;
      if (in_ready[1] === 1'b1) gr1++;
      if (out_valid[1] === 1'b1 && out_data[1] !== 64'h10fedcba98765432) bad1++;
      step();
    end
    n_total++; if (bad0 != 0) $display("FAIL stall_ready0: got %0d grants want 0", bad0); else n_pass++;
    n_total++; if (gr1 < 2) $display("FAIL stall_req1_served: got %0d grants want >=2", gr1); else n_pass++;
    n_total++; if (bad1 != 0) $display("FAIL stall_req1_data: got %0d bad want 0", bad1); else n_pass++;
    n_total++; if (out_valid[0] !== 1'b1 || out_data[0] !== 64'h7788112233445566)
      $display("FAIL stall_req0_kept: got v=%b d=%h want v=1 d=7788112233445566", out_valid[0], out_data[0]);
    else n_pass++;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    step();
    n_total++; if (out_valid[0] !== 1'b0) $display("FAIL stall_req0_drained: got %b want 0", out_valid[0]); else n_pass++;
    drain(6);
  endtask

  task automatic test_shift_edges();
    logic [63:0] r;
    logic        ok;
    run_op(0, 64'h8000000000000001, 6'd0, r, ok);
    n_total++; if (!ok || r !== 64'h8000000000000001)
      $display("FAIL shift0: got ok=%b %h want ok=1 8000000000000001", ok, r);
    else n_pass++;
    run_op(1, 64'h8000000000000001, 6'd63, r, ok);
    n_total++; if (!ok || r !== 64'h0000000000000003)
      $display("FAIL shift63: got ok=%b %h want ok=1 0000000000000003", ok, r);
    else n_pass++;
  endtask

  task automatic test_stat();
    logic [63:0] r;
    logic        ok;
    int          nok;
    logic [CNT_W-1:0] e0, e1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    nok = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(0, 64'h00000000000000f0, 6'd4, r, ok);
      if (!ok || r !== 64'h000000000000000f) nok++;
    end
    for (int i = 0; i < 3; i++) begin
      run_op(1, 64'h0000000000000100, 6'd8, r, ok);
      if (!ok || r !== 64'h0000000000000001) nok++;
    end
`ifdef ROTR_ARB_STAT_EN
    e0 = CNT_W'(5);
    e1 = CNT_W'(3);
`else
    e0 = '0;
    e1 = '0;
`endif
    n_total++; if (nok != 0) $display("FAIL stat_ops: got %0d bad ops want 0", nok); else n_pass++;
    n_total++; if (stat_cnt[0] !== e0) $display("FAIL stat_cnt0: got %0d want %0d", stat_cnt[0], e0); else n_pass++;
    n_total++; if (stat_cnt[1] !== e1) $display("FAIL stat_cnt1: got %0d want %0d", stat_cnt[1], e1); else n_pass++;
  endtask

  task automatic test_reset_midop();
    in_data[0]  = 64'hdeadbeefcafef00d;
    in_shift[0] = 6'd12;
    out_ready   = 2'b11;
    in_valid    = 2'b01;
    #1;
    n_total++; if (err !== 1'b0) $display("FAIL midop_err_before: got %b want 0", err); else n_pass++;
    step();
    n_total++; if (rot_valid_o !== 1'b1) $display("FAIL midop_in_flight: got %b want 1", rot_valid_o); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (in_ready !== 2'b00) $display("FAIL midop_ready_in_reset: got %b want 00", in_ready); else n_pass++;
    step();
    rst      = 1'b0;
    in_valid = 2'b00;
    #1;
    n_total++; if (rot_valid_i !== 1'b1 || err !== 1'b0)
      $display("FAIL midop_late_strobe: got rv=%b err=%b want rv=1 err=0", rot_valid_i, err);
    else n_pass++;
    step();
    n_total++; if (err !== 1'b1 || out_valid !== 2'b00)
      $display("FAIL midop_err: got err=%b v=%b want err=1 v=00", err, out_valid);
    else n_pass++;
    drain(3);
    n_total++; if (err !== 1'b1 || out_valid !== 2'b00)
      $display("FAIL midop_err_sticky: got err=%b v=%b want err=1 v=00", err, out_valid);
    else n_pass++;
    in_valid = 2'b01;
    #1;
    n_total++; if (in_ready !== 2'b01) $display("FAIL midop_pend_dropped: got %b want 01", in_ready); else n_pass++;
    in_valid = 2'b00;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    in_shift  = '0;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_shift_edges();
    test_stat();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rotr_arb_64b.md
ROTR_ARB_64B -- requirements
Module: rotr_arb_64b

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of per-requester grant counters.
REQ-002 SHALL have port clk_i, input, 1, single clock; all logic rising-edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_data_i, input, 2x64, operand per requester k (k=0,1).
REQ-005 SHALL have port in_shift_i, input, 2x6, right-rotate amount per requester.
REQ-006 SHALL have port in_valid_i, input, 2, request valid per requester.
REQ-007 SHALL have port in_ready_o, output, 2, request accepted per requester.
REQ-008 SHALL have port out_data_o, output, 2x64, rotated result per requester.
REQ-009 SHALL have port out_valid_o, output, 2, result valid per requester.
REQ-010 SHALL have port out_ready_i, input, 2, result consumed per requester.
REQ-011 SHALL have port rot_data_o, output, 64, operand to shared rotator.
REQ-012 SHALL have port rot_shift_o, output, 6, shift to shared rotator.
REQ-013 SHALL have port rot_valid_o, output, 1, issue strobe to rotator.
REQ-014 SHALL have port rot_data_i, input, 64, rotator result.
REQ-015 SHALL have port rot_valid_i, input, 1, rotator result strobe (any fixed latency >= 0 cycles after issue).
REQ-016 SHALL have port err_o, output, 1, sticky protocol error.
REQ-017 SHALL have port stat_cnt_o, output, 2xCNT_W, grants per requester.

Function
REQ-018 SHALL keep pend[k] per requester; at most one outstanding operation per requester.
REQ-019 SHALL make requester k eligible when in_valid_i[k]=1 and pend[k]=0.
REQ-020 SHALL grant at most one requester per cycle; in_ready_o[k]=1 only for the winner (combinational from in_valid_i and registers).
REQ-021 SHALL arbitrate round-robin: both eligible -> grant the one not granted last; pointer updates only on a grant; reset pointer favours requester 0.
REQ-022 SHALL, on grant in cycle T, drive rot_valid_o=1 with registered rot_data_o/rot_shift_o in cycle T+1, set pend[k], and push tag k into a 2-entry tag FIFO.
REQ-023 SHALL hold rot_valid_o=0 in cycles without a preceding grant; rot_data_o/rot_shift_o hold last value.
REQ-024 SHALL, on rot_valid_i=1, pop the tag FIFO, load out_data_o[tag]=rot_data_i, set out_valid_o[tag]=1.
REQ-025 SHALL hold out_valid_o[k] and out_data_o[k] stable until out_valid_o[k]&out_ready_i[k]; then clear out_valid_o[k] and pend[k] in the same edge.
REQ-026 SHALL allow a new grant to requester k no earlier than the cycle after its result transfer.
REQ-027 SHALL allow a push and pop of the tag FIFO in the same cycle.
REQ-028 SHALL discard rot_valid_i with empty tag FIFO and set err_o=1 until reset.
REQ-029 SHALL ignore out_ready_i[k] while out_valid_o[k]=0.

Reset
REQ-030 SHALL, with rst_i=1 at a clock edge, clear pend, tag FIFO, out_valid_o, rot_valid_o, err_o, stat_cnt_o, and set pointer to favour requester 0.
REQ-031 SHALL reset out_data_o, rot_data_o, rot_shift_o to 0.
REQ-032 SHALL drop all in-flight operations on reset mid-operation; late rot_valid_i after reset SHALL set err_o per REQ-028.
REQ-033 SHALL drive in_ready_o=0 while rst_i=1.

Configuration
REQ-034 SHALL compile grant counters only when macro ROTR_ARB_STAT_EN is defined: stat_cnt_o[k] increments per grant to k, saturates at all-ones.
REQ-035 SHALL, without ROTR_ARB_STAT_EN, tie stat_cnt_o to 0 and instantiate no counter flops; all other behaviour unchanged.

Verification (bench models rotator with latency 1)
REQ-036 SHALL cover: req0 data 0x0123456789abcdef shift 4 -> rot_valid_o next cycle, out_data_o[0]=0xf0123456789abcde, out_valid_o[0] held until out_ready_i[0].
REQ-037 SHALL cover: both valid continuously, out_ready_i=11 -> grants alternate 0,1,0,1; req1 data 0xfedcba9876543210 shift 8 -> 0x10fedcba98765432.
REQ-038 SHALL cover: out_ready_i[0]=0 for 10 cycles -> in_ready_o[0]=0 throughout, req1 still served, no result lost.
REQ-039 SHALL cover: shift 0 and shift 63 on 0x8000000000000001 -> 0x8000000000000001 and 0x0000000000000003.
REQ-040 SHALL cover: rst_i pulsed with one op in flight, then rot_valid_i=1 -> no out_valid_o, err_o=1.
REQ-041 SHALL cover: with ROTR_ARB_STAT_EN, 5 grants to req0, 3 to req1 -> stat_cnt_o=(5,3); without macro -> (0,0).
